// File: rtl/eth_pkt_scheduler_if.sv
// rtl/eth_pkt_scheduler_if.sv - source, writer-FIFO and writer-handshake signals of the ethernet packet scheduler
interface eth_pkt_scheduler_if;
  logic        proc_req;
  logic [10:0] proc_len;
  logic [7:0]  proc_fft_size;
  logic [31:0] proc_data;
  logic        proc_valid;
  logic        proc_rd;
  logic        proc_done;
  logic        raw_req;
  logic [31:0] raw_data;
  logic        raw_valid;
  logic        raw_rd;
  logic        raw_done;
  logic [31:0] eth_data;
  logic        eth_data_we;
  logic        eth_fifo_full;
  logic [10:0] eth_length;
  logic [7:0]  fft_size;
  logic        raw_packet;
  logic        packet_ready;
  logic        packet_busy;
  logic        timeout_err;

  modport master (
    input  proc_req, proc_len, proc_fft_size, proc_data, proc_valid,
    input  raw_req, raw_data, raw_valid, eth_fifo_full, packet_busy,
    output proc_rd, proc_done, raw_rd, raw_done, eth_data, eth_data_we,
    output eth_length, fft_size, raw_packet, packet_ready, timeout_err
  );

  modport slave (
    output proc_req, proc_len, proc_fft_size, proc_data, proc_valid,
    output raw_req, raw_data, raw_valid, eth_fifo_full, packet_busy,
    input  proc_rd, proc_done, raw_rd, raw_done, eth_data, eth_data_we,
    input  eth_length, fft_size, raw_packet, packet_ready, timeout_err
  );
endinterface

// File: rtl/eth_pkt_scheduler.sv
// rtl/eth_pkt_scheduler.sv - round-robin scheduler of processed/raw payloads onto the ethernet writer
// Optional per-source handoff and timeout counters: define ETH_SCHED_STATS_EN.
module eth_pkt_scheduler #(
  parameter int MAX_WORDS = 256,
  parameter int TIMEOUT   = 4095
) (
  input  logic                  clk_ext,
  input  logic                  rst,
  eth_pkt_scheduler_if.master   bus
`ifdef ETH_SCHED_STATS_EN
  ,
  output logic [31:0]           proc_pkt_cnt,
  output logic [31:0]           raw_pkt_cnt,
  output logic [15:0]           to_cnt
`endif
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_ARB      = 3'd1;
  localparam logic [2:0] S_STREAM   = 3'd2;
  localparam logic [2:0] S_ANNOUNCE = 3'd3;
  localparam logic [2:0] S_WAIT_HI  = 3'd4;
  localparam logic [2:0] S_WAIT_LO  = 3'd5;

  localparam logic OWN_PROC = 1'b0;
  localparam logic OWN_RAW  = 1'b1;

  localparam logic [10:0] MAX_LEN = 11'(MAX_WORDS);
  localparam int          TW      = $clog2(TIMEOUT + 1);

  logic [2:0]    state_q, state_d;
  logic          owner_q, owner_d;
  logic          last_grant_q, last_grant_d;
  logic [10:0]   len_q, len_d;
  logic [10:0]   wcnt_q, wcnt_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          busy_m_q, busy_s_q;
  logic [31:0]   eth_data_q, eth_data_d;
  logic          eth_we_q, eth_we_d;
  logic [7:0]    fft_size_q, fft_size_d;
  logic          raw_packet_q, raw_packet_d;
  logic          packet_ready_q, packet_ready_d;
  logic          timeout_err_q, timeout_err_d;
  logic          proc_done_q, proc_done_d;
  logic          raw_done_q, raw_done_d;

  logic          stream_rd;
  logic          owner_valid;
  logic [31:0]   owner_data;

  // Read strobe is combinational so it drops in the very cycle the last word is taken.
  assign stream_rd   = (state_q == S_STREAM) && !bus.eth_fifo_full && (wcnt_q != len_q);
  assign owner_valid = (owner_q == OWN_RAW) ? bus.raw_valid : bus.proc_valid;
  assign owner_data  = (owner_q == OWN_RAW) ? bus.raw_data  : bus.proc_data;

  assign bus.proc_rd      = stream_rd && (owner_q == OWN_PROC);
  assign bus.raw_rd       = stream_rd && (owner_q == OWN_RAW);
  assign bus.proc_done    = proc_done_q;
  assign bus.raw_done     = raw_done_q;
  assign bus.eth_data     = eth_data_q;
  assign bus.eth_data_we  = eth_we_q;
  assign bus.eth_length   = len_q;
  assign bus.fft_size     = fft_size_q;
  assign bus.raw_packet   = raw_packet_q;
  assign bus.packet_ready = packet_ready_q;
  assign bus.timeout_err  = timeout_err_q;

  always_comb begin
    state_d        = state_q;
    owner_d        = owner_q;
    last_grant_d   = last_grant_q;
    len_d          = len_q;
    wcnt_d         = wcnt_q;
    tmo_d          = tmo_q;
    eth_data_d     = eth_data_q;
    eth_we_d       = 1'b0;
    fft_size_d     = fft_size_q;
    raw_packet_d   = raw_packet_q;
    packet_ready_d = packet_ready_q;
    timeout_err_d  = 1'b0;
    proc_done_d    = 1'b0;
    raw_done_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if ((bus.proc_req || bus.raw_req) && !busy_s_q) begin
          if (bus.proc_req && bus.raw_req)
            owner_d = (last_grant_q == OWN_RAW) ? OWN_PROC : OWN_RAW;
          else
            owner_d = bus.raw_req ? OWN_RAW : OWN_PROC;
          state_d = S_ARB;
        end
      end
      S_ARB: begin
        wcnt_d = '0;
        if (owner_q == OWN_RAW) begin
          len_d        = MAX_LEN;
          fft_size_d   = 8'd0;
          raw_packet_d = 1'b1;
          state_d      = S_STREAM;
        end else begin
          len_d        = (bus.proc_len > MAX_LEN) ? MAX_LEN : bus.proc_len;
          fft_size_d   = bus.proc_fft_size;
          raw_packet_d = 1'b0;
          if (bus.proc_len == 11'd0) begin
            proc_done_d = 1'b1;
            state_d     = S_IDLE;
          end else begin
            state_d = S_STREAM;
          end
        end
      end
      S_STREAM: begin
        if (stream_rd && owner_valid) begin
          eth_data_d = owner_data;
          eth_we_d   = 1'b1;
          wcnt_d     = wcnt_q + 11'd1;
          if (wcnt_q + 11'd1 == len_q)
            state_d = S_ANNOUNCE;
        end
      end
      S_ANNOUNCE: begin
        packet_ready_d = 1'b1;
        tmo_d          = '0;
        state_d        = S_WAIT_HI;
      end
      S_WAIT_HI: begin
        if (busy_s_q) begin
          packet_ready_d = 1'b0;
          state_d        = S_WAIT_LO;
        end else if (tmo_q == TW'(TIMEOUT)) begin
          packet_ready_d = 1'b0;
          timeout_err_d  = 1'b1;
          proc_done_d    = (owner_q == OWN_PROC);
          raw_done_d     = (owner_q == OWN_RAW);
          state_d        = S_IDLE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      S_WAIT_LO: begin
        if (!busy_s_q) begin
          proc_done_d  = (owner_q == OWN_PROC);
          raw_done_d   = (owner_q == OWN_RAW);
          last_grant_d = owner_q;
          state_d      = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_ext) begin
    if (rst) begin
      state_q        <= S_IDLE;
      owner_q        <= OWN_PROC;
      last_grant_q   <= OWN_RAW;
      len_q          <= '0;
      wcnt_q         <= '0;
      tmo_q          <= '0;
      busy_m_q       <= 1'b0;
      busy_s_q       <= 1'b0;
      eth_data_q     <= '0;
      eth_we_q       <= 1'b0;
      fft_size_q     <= '0;
      raw_packet_q   <= 1'b0;
      packet_ready_q <= 1'b0;
      timeout_err_q  <= 1'b0;
      proc_done_q    <= 1'b0;
      raw_done_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      owner_q        <= owner_d;
      last_grant_q   <= last_grant_d;
      len_q          <= len_d;
      wcnt_q         <= wcnt_d;
      tmo_q          <= tmo_d;
      busy_m_q       <= bus.packet_busy;
      busy_s_q       <= busy_m_q;
      eth_data_q     <= eth_data_d;
      eth_we_q       <= eth_we_d;
      fft_size_q     <= fft_size_d;
      raw_packet_q   <= raw_packet_d;
      packet_ready_q <= packet_ready_d;
      timeout_err_q  <= timeout_err_d;
      proc_done_q    <= proc_done_d;
      raw_done_q     <= raw_done_d;
    end
  end

`ifdef ETH_SCHED_STATS_EN
  logic [31:0] proc_cnt_q;
  logic [31:0] raw_cnt_q;
  logic [15:0] to_cnt_q;
  logic        handoff;

  // A completed handoff is the WAIT_LO exit; timeouts are tallied separately.
  assign handoff = (state_q == S_WAIT_LO) && !busy_s_q;

  always_ff @(posedge clk_ext) begin
    if (rst) begin
      proc_cnt_q <= '0;
      raw_cnt_q  <= '0;
      to_cnt_q   <= '0;
    end else begin
      if (handoff && owner_q == OWN_PROC) proc_cnt_q <= proc_cnt_q + 32'd1;
      if (handoff && owner_q == OWN_RAW)  raw_cnt_q  <= raw_cnt_q + 32'd1;
      if (timeout_err_d)                  to_cnt_q   <= to_cnt_q + 16'd1;
    end
  end

  assign proc_pkt_cnt = proc_cnt_q;
  assign raw_pkt_cnt  = raw_cnt_q;
  assign to_cnt       = to_cnt_q;
`endif

endmodule

// File: tb/tb_eth_pkt_scheduler.sv
// tb/tb_eth_pkt_scheduler.sv - scoreboard bench for eth_pkt_scheduler with randomized sources
module tb_eth_pkt_scheduler;
  localparam int MAXW    = 256;
  localparam int TMO     = 4095;
  localparam logic [31:0] PROC_TAG = 32'hA000_0000;
  localparam logic [31:0] RAW_TAG  = 32'hB000_0000;

  typedef struct {
    bit raw;
    int len;
    int fft;
    bit tmo;
  } pkt_t;

  logic clk_ext;
  logic rst;
  eth_pkt_scheduler_if bus();

`ifdef ETH_SCHED_STATS_EN
  logic [31:0] proc_pkt_cnt;
  logic [31:0] raw_pkt_cnt;
  logic [15:0] to_cnt;
  eth_pkt_scheduler #(.MAX_WORDS(MAXW), .TIMEOUT(TMO)) dut (
    .clk_ext(clk_ext), .rst(rst), .bus(bus),
    .proc_pkt_cnt(proc_pkt_cnt), .raw_pkt_cnt(raw_pkt_cnt), .to_cnt(to_cnt)
  );
`else
  eth_pkt_scheduler #(.MAX_WORDS(MAXW), .TIMEOUT(TMO)) dut (
    .clk_ext(clk_ext), .rst(rst), .bus(bus)
  );
`endif

  int   n_vec = 0;
  int   n_err = 0;
  pkt_t exp_q[$];
  logic [31:0] cur_q[$];
  int   pr_cycles = 0;
  bit   prev_pr = 0;
  bit   m_last = 1;
  bit   writer_en = 1;
  bit   force_full = 0;
  bit   rand_full_en = 0;

  initial begin
    clk_ext = 0;
    forever #5 clk_ext = ~clk_ext;
  end

  task automatic chk(input string name, input longint act, input longint req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  function automatic logic [63:0] out_vec();
    return 64'({bus.proc_rd, bus.raw_rd, bus.proc_done, bus.raw_done, bus.eth_data_we,
                bus.eth_data, bus.eth_length, bus.fft_size, bus.raw_packet,
                bus.packet_ready, bus.timeout_err});
  endfunction

  // Reference arbitration: round robin on a tie, otherwise the sole requester.
  function automatic bit pick(input bit p, input bit r);
    if (p && r) return (m_last == 1'b1) ? 1'b0 : 1'b1;
    return r;
  endfunction

  task automatic push_exp(input bit raw, input int plen, input int fft, input bit tmo);
    pkt_t e;
    e.raw = raw;
    e.len = raw ? MAXW : ((plen > MAXW) ? MAXW : plen);
    e.fft = raw ? 0 : fft;
    e.tmo = tmo;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk_ext);
    #1;
  endtask

  task automatic wait_rd(input bit raw);
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk_ext);
      if (raw ? bus.raw_rd : bus.proc_rd) return;
    end
    chk(raw ? "wait_raw_rd" : "wait_proc_rd", 0, 1);
  endtask

  task automatic wait_done(input bit raw, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk_ext);
      if (raw ? bus.raw_done : bus.proc_done) return;
    end
    chk(raw ? "wait_raw_done" : "wait_proc_done", 0, 1);
  endtask

  task automatic send(input bit raw, input int plen, input int fft, input bit tmo);
    push_exp(raw, plen, fft, tmo);
    if (raw) bus.raw_req = 1;
    else begin
      bus.proc_req = 1;
      bus.proc_len = 11'(plen);
      bus.proc_fft_size = 8'(fft);
    end
    wait_rd(raw);
    tick();
    if (raw) bus.raw_req = 0;
    else bus.proc_req = 0;
    wait_done(raw, tmo ? 6000 : 3000);
    if (!tmo) m_last = raw;
  endtask

  // Sources: word n of a packet carries tag|n; valid and FIFO-full are randomized.
  initial begin
    int  pidx = 0;
    int  ridx = 0;
    bit  tp, tr, dp, dr, r;
    bus.proc_valid = 0;
    bus.raw_valid = 0;
    bus.proc_data = PROC_TAG;
    bus.raw_data = RAW_TAG;
    bus.eth_fifo_full = 0;
    forever begin
      @(negedge clk_ext);
      tp = bus.proc_rd && bus.proc_valid;
      tr = bus.raw_rd && bus.raw_valid;
      dp = bus.proc_done;
      dr = bus.raw_done;
      r  = rst;
      @(posedge clk_ext);
      #2;
      if (r) begin
        pidx = 0;
        ridx = 0;
      end else begin
        if (tp) pidx++;
        if (tr) ridx++;
        if (dp) pidx = 0;
        if (dr) ridx = 0;
      end
      bus.proc_valid = ($urandom % 4) != 0;
      bus.raw_valid  = ($urandom % 4) != 0;
      bus.proc_data  = PROC_TAG | 32'(pidx);
      bus.raw_data   = RAW_TAG | 32'(ridx);
      bus.eth_fifo_full = force_full | (rand_full_en && ($urandom % 3 == 0));
    end
  end

  // Writer: after a short random delay, holds packet_busy for 20 cycles per announced packet.
  initial begin
    bus.packet_busy = 0;
    forever begin
      @(negedge clk_ext);
      if (bus.packet_ready && writer_en && !rst) begin
        repeat ($urandom_range(0, 4)) @(posedge clk_ext);
        #1 bus.packet_busy = 1;
        repeat (20) @(posedge clk_ext);
        #1 bus.packet_busy = 0;
      end
    end
  end

  always @(negedge clk_ext) begin
    if (rst) begin
      exp_q.delete();
      cur_q.delete();
      pr_cycles = 0;
      prev_pr = 0;
    end else begin
      if (bus.eth_data_we) cur_q.push_back(bus.eth_data);
      if (bus.packet_ready && !prev_pr) begin
        if (exp_q.size() == 0) chk("unexpected_ready", 1, 0);
        else begin
          chk("eth_length", bus.eth_length, exp_q[0].len);
          chk("fft_size", bus.fft_size, exp_q[0].fft);
          chk("raw_packet", bus.raw_packet, exp_q[0].raw);
          chk("words_before_ready", cur_q.size(), exp_q[0].len);
        end
      end
      if (bus.packet_ready) pr_cycles++;
      prev_pr = bus.packet_ready;
      if (bus.proc_done || bus.raw_done) begin
        if (exp_q.size() == 0) chk("unexpected_done", 1, 0);
        else begin
          pkt_t e;
          int bad;
          logic [31:0] tag;
          e = exp_q.pop_front();
          tag = e.raw ? RAW_TAG : PROC_TAG;
          bad = 0;
          for (int i = 0; i < cur_q.size(); i++)
            if (cur_q[i] !== (tag | 32'(i))) bad++;
          chk("done_source", bus.raw_done, e.raw);
          chk("both_done", bus.proc_done && bus.raw_done, 0);
          chk("timeout_err", bus.timeout_err, e.tmo);
          chk("word_count", cur_q.size(), e.len);
          chk("data_sequence_errors", bad, 0);
          if (e.tmo) chk("timeout_window", (pr_cycles >= TMO && pr_cycles <= TMO + 2), 1);
        end
        cur_q.delete();
        pr_cycles = 0;
      end
    end
  end

  initial begin
    rst = 1;
    bus.proc_req = 0;
    bus.raw_req = 0;
    bus.proc_len = 0;
    bus.proc_fft_size = 0;
    repeat (3) tick();
    @(negedge clk_ext);
    chk("reset_outputs", out_vec(), 0);
    tick();
    rst = 0;

    send(0, 8, 8, 0);

    for (int round = 0; round < 2; round++) begin
      bit w;
      w = pick(1, 1);
      push_exp(w, 12, 5, 0);
      push_exp(!w, 12, 5, 0);
      bus.proc_len = 11'd12;
      bus.proc_fft_size = 8'd5;
      bus.proc_req = 1;
      bus.raw_req = 1;
      wait_rd(w);
      tick();
      if (w) bus.raw_req = 0; else bus.proc_req = 0;
      wait_done(w, 3000);
      m_last = w;
      wait_rd(!w);
      tick();
      if (w) bus.proc_req = 0; else bus.raw_req = 0;
      wait_done(!w, 3000);
      m_last = !w;
    end

    push_exp(0, 40, 6, 0);
    bus.proc_len = 11'd40;
    bus.proc_fft_size = 8'd6;
    bus.proc_req = 1;
    wait_rd(0);
    tick();
    bus.proc_req = 0;
    repeat (3) tick();
    force_full = 1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_ext);
      chk("proc_rd_while_full", bus.proc_rd, 0);
    end
    tick();
    force_full = 0;
    wait_done(0, 3000);
    m_last = 0;

    send(0, 2000, 9, 0);

    rand_full_en = 1;
    for (int i = 0; i < 6; i++)
      send(bit'($urandom % 2), 1 + int'($urandom % 64), int'($urandom_range(3, 13)), 0);
    rand_full_en = 0;

    writer_en = 0;
    send(0, 4, 8, 1);
    writer_en = 1;
    send(0, 6, 3, 0);

    push_exp(0, 100, 4, 0);
    bus.proc_len = 11'd100;
    bus.proc_fft_size = 8'd4;
    bus.proc_req = 1;
    wait_rd(0);
    tick();
    bus.proc_req = 0;
    repeat (5) tick();
    rst = 1;
    tick();
    rst = 0;
    @(negedge clk_ext);
    chk("reset_midstream_outputs", out_vec(), 0);
    m_last = 1;
    send(0, 16, 7, 0);

    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk_ext);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
